// File: rtl/recip_scale_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : recip_scale_pipe_if
// Description : Handshake/data bundle for recip_scale_pipe.
//               Input side : in_valid/in_ready, D, X, One_by_N, in_tag
//               Output side: out_valid/out_ready, Q, out_tag
//               Status     : clamp_err (sticky), clamp_clr (clear)
//               master = upstream/downstream agent, slave = the scaler.
// Revision    : 1.0 - initial release
// ============================================================================
interface recip_scale_pipe_if #(
    parameter int DW   = 32,
    parameter int FRAC = 16,
    parameter int TAGW = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   D;
    logic [DW-1:0]   X;
    logic [FRAC:0]   One_by_N;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   Q;
    logic [TAGW-1:0] out_tag;
    logic            clamp_err;
    logic            clamp_clr;

    modport master (
        output in_valid, D, X, One_by_N, in_tag, out_ready, clamp_clr,
        input  in_ready, out_valid, Q, out_tag, clamp_err
    );

    modport slave (
        input  in_valid, D, X, One_by_N, in_tag, out_ready, clamp_clr,
        output in_ready, out_valid, Q, out_tag, clamp_err
    );
endinterface
`default_nettype wire

// File: rtl/recip_scale_pipe.sv
`default_nettype none
// ============================================================================
// Module      : recip_scale_pipe
// Description : Three-stage pipelined decay scaler, Q = floor(D*(1 - 1/N)),
//               with 1/N given as One_by_N in unsigned FRAC-bit fixed point.
//               Valid/ready flow control with a single global advance, a
//               pass-through tag, and a sticky clamp flag for One_by_N > 1.0.
//               Optional macro RECIP_EMA_EN adds the EMA term X*(1/N).
// Ports       : clk, rst (async, active-high)
//               bus (recip_scale_pipe_if.slave): in_valid/in_ready, D, X,
//               One_by_N, in_tag, out_valid/out_ready, Q, out_tag,
//               clamp_err, clamp_clr
// Revision    : 1.0 - initial release
// ============================================================================
module recip_scale_pipe #(
    parameter int DW   = 32,
    parameter int FRAC = 16,
    parameter int TAGW = 4
) (
    input wire                 clk,
    input wire                 rst,
    recip_scale_pipe_if.slave  bus
);
    localparam int c_HW = DW / 2;          // half-word width
    localparam int c_PW = c_HW + FRAC + 1; // partial product width
    localparam int c_SW = DW + FRAC + 1;   // full product width
    localparam logic [FRAC:0] c_ONE = {1'b1, {FRAC{1'b0}}};

    // Stage registers
    logic            r_s1_valid, r_s2_valid, r_s3_valid;
    logic [TAGW-1:0] r_s1_tag, r_s2_tag, r_s3_tag;
    logic [DW-1:0]   r_s1_d;
    logic [FRAC:0]   r_s1_t;
    logic [c_PW-1:0] r_s2_ph, r_s2_pl;
    logic [DW-1:0]   r_s3_q;
    logic            r_clamp_err;

    logic            w_adv;
    logic            w_in_xfer;
    logic            w_over;
    logic [FRAC:0]   w_recip;
    logic [FRAC:0]   w_t;
    logic [c_SW-1:0] w_sum;
    logic            w_unused_bits;

    // The whole pipe moves together: it may shift whenever the output slot
    // is empty or being drained this cycle.
    assign w_adv        = !r_s3_valid || bus.out_ready;
    assign bus.in_ready = w_adv;
    assign w_in_xfer    = bus.in_valid && w_adv;

    assign w_over  = (bus.One_by_N > c_ONE);
    assign w_recip = w_over ? c_ONE : bus.One_by_N;
    assign w_t     = c_ONE - w_recip;

    // Sticky clamp flag; a new clamp event outranks a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clamp_err <= 1'b0;
        end else if (w_in_xfer && w_over) begin
            r_clamp_err <= 1'b1;
        end else if (bus.clamp_clr) begin
            r_clamp_err <= 1'b0;
        end
    end

    // S1: register operands and the complementary factor t
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_tag   <= '0;
            r_s1_d     <= '0;
            r_s1_t     <= '0;
        end else if (w_adv) begin
            r_s1_valid <= bus.in_valid;
            r_s1_tag   <= bus.in_tag;
            r_s1_d     <= bus.D;
            r_s1_t     <= w_t;
        end
    end

    // S2: half-width partial products keep each multiplier narrow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_tag   <= '0;
            r_s2_ph    <= '0;
            r_s2_pl    <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_tag   <= r_s1_tag;
            r_s2_ph    <= c_PW'(r_s1_d[DW-1:c_HW]) * c_PW'(r_s1_t);
            r_s2_pl    <= c_PW'(r_s1_d[c_HW-1:0])  * c_PW'(r_s1_t);
        end
    end

`ifdef RECIP_EMA_EN
    // EMA term: X weighted by u = 1.0 - t, which is the clamped 1/N
    logic [DW-1:0]   r_s1_x;
    logic [c_PW-1:0] r_s2_xh, r_s2_xl;
    logic [FRAC:0]   w_u;

    assign w_u = c_ONE - r_s1_t;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_x  <= '0;
            r_s2_xh <= '0;
            r_s2_xl <= '0;
        end else if (w_adv) begin
            r_s1_x  <= bus.X;
            r_s2_xh <= c_PW'(r_s1_x[DW-1:c_HW]) * c_PW'(w_u);
            r_s2_xl <= c_PW'(r_s1_x[c_HW-1:0])  * c_PW'(w_u);
        end
    end

    // D*t + X*u <= max(D,X) * 2^FRAC, so c_SW bits cannot overflow
    assign w_sum = (c_SW'(r_s2_ph) << c_HW) + c_SW'(r_s2_pl)
                 + (c_SW'(r_s2_xh) << c_HW) + c_SW'(r_s2_xl);
    assign w_unused_bits = ^{w_sum[FRAC-1:0], w_sum[c_SW-1]};
`else
    assign w_sum = (c_SW'(r_s2_ph) << c_HW) + c_SW'(r_s2_pl);
    // X is not part of the plain decay datapath
    assign w_unused_bits = ^{w_sum[FRAC-1:0], w_sum[c_SW-1], bus.X};
`endif

    // S3: recombine and drop the fraction bits (floor)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
            r_s3_tag   <= '0;
            r_s3_q     <= '0;
        end else if (w_adv) begin
            r_s3_valid <= r_s2_valid;
            r_s3_tag   <= r_s2_tag;
            r_s3_q     <= w_sum[FRAC +: DW];
        end
    end

    assign bus.out_valid = r_s3_valid;
    assign bus.Q         = r_s3_q;
    assign bus.out_tag   = r_s3_tag;
    assign bus.clamp_err = r_clamp_err;

endmodule
`default_nettype wire

// File: tb/tb_recip_scale_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_recip_scale_pipe
// Description : Self-checking bench for recip_scale_pipe: directed cases plus
//               randomized traffic against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_recip_scale_pipe;
    localparam int DW   = 32;
    localparam int FRAC = 16;
    localparam int TAGW = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    recip_scale_pipe_if #(.DW(DW), .FRAC(FRAC), .TAGW(TAGW)) bus ();

    recip_scale_pipe #(.DW(DW), .FRAC(FRAC), .TAGW(TAGW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: clamp 1/N to 1.0, then floor((D*(1-r) [+ X*r]) / 2^16)
    function automatic logic [31:0] model_q(input logic [31:0] d, input logic [31:0] x,
                                            input logic [16:0] r);
        longint unsigned rc, p;
        logic [63:0]     pv;
        rc = (r > 17'h10000) ? 64'd65536 : 64'(r);
        p  = 64'(d) * (64'd65536 - rc);
`ifdef RECIP_EMA_EN
        p  = p + 64'(x) * rc;
`else
        if (x == 32'hFFFF_FFFF) p = p + 64'd0;
`endif
        pv = p;
        return pv[47:16];
    endfunction

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.D         = '0;
        bus.X         = '0;
        bus.One_by_N  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        bus.clamp_clr = 1'b0;
    endtask

    // Present one beat into an empty pipe and wait for its result.
    // Called and returns at posedge+1.
    task automatic send_one(input logic [31:0] d, input logic [31:0] x, input logic [16:0] r,
                            input logic [3:0] tg, output logic [31:0] q_o,
                            output logic [3:0] tag_o, output int lat);
        bus.in_valid = 1'b1;
        bus.D        = d;
        bus.X        = x;
        bus.One_by_N = r;
        bus.in_tag   = tg;
        lat   = -1;
        q_o   = '0;
        tag_o = '0;
        @(negedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            if (bus.out_valid) begin
                lat   = n;
                q_o   = bus.Q;
                tag_o = bus.out_tag;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
        checks++; if (bus.Q !== 32'h0) begin errors++; $display("FAIL reset_q: got %h expected 0", bus.Q); end
        checks++; if (bus.out_tag !== 4'h0) begin errors++; $display("FAIL reset_tag: got %h expected 0", bus.out_tag); end
        checks++; if (bus.clamp_err !== 1'b0) begin errors++; $display("FAIL reset_clamp: got %0b expected 0", bus.clamp_err); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] q; logic [3:0] tg; int lat;
        send_one(32'h0001_0000, 32'h0, 17'h01000, 4'hA, q, tg, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", lat); end
        checks++; if (q !== 32'h0000_F000) begin errors++; $display("FAIL basic_q: got %h expected 0000f000", q); end
        checks++; if (tg !== 4'hA) begin errors++; $display("FAIL basic_tag: got %h expected a", tg); end
    endtask

    task automatic test_boundaries();
        logic [31:0] q; logic [3:0] tg; int lat;
        send_one(32'hFFFF_FFFF, 32'h0, 17'h00000, 4'h1, q, tg, lat);
        checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bound_zero_recip: got %h expected ffffffff", q); end
        send_one(32'h1234_5678, 32'h0, 17'h10000, 4'h2, q, tg, lat);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL bound_one_recip: got %h expected 0", q); end
        send_one(32'h3, 32'h0, 17'h08000, 4'h3, q, tg, lat);
        checks++; if (q !== 32'h1) begin errors++; $display("FAIL bound_floor: got %h expected 1", q); end
        checks++; if (bus.clamp_err !== 1'b0) begin errors++; $display("FAIL bound_no_clamp: got %0b expected 0", bus.clamp_err); end
    endtask

    task automatic test_clamp();
        logic [31:0] q; logic [3:0] tg; int lat;
        send_one(32'h0000_1234, 32'h0, 17'h1FFFF, 4'h4, q, tg, lat);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL clamp_q: got %h expected 0", q); end
        checks++; if (bus.clamp_err !== 1'b1) begin errors++; $display("FAIL clamp_set: got %0b expected 1", bus.clamp_err); end
        send_one(32'h0000_8000, 32'h0, 17'h04000, 4'h5, q, tg, lat);
        checks++; if (bus.clamp_err !== 1'b1) begin errors++; $display("FAIL clamp_sticky: got %0b expected 1", bus.clamp_err); end
        checks++; if (q !== 32'h0000_6000) begin errors++; $display("FAIL clamp_legal_q: got %h expected 6000", q); end
        bus.clamp_clr = 1'b1;
        @(posedge clk); #1;
        bus.clamp_clr = 1'b0;
        checks++; if (bus.clamp_err !== 1'b0) begin errors++; $display("FAIL clamp_clear: got %0b expected 0", bus.clamp_err); end
        // set and clear in the same cycle: set must win
        bus.in_valid  = 1'b1;
        bus.D         = 32'h5;
        bus.One_by_N  = 17'h1FFFF;
        bus.in_tag    = 4'h6;
        bus.clamp_clr = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.clamp_clr = 1'b0;
        checks++; if (bus.clamp_err !== 1'b1) begin errors++; $display("FAIL clamp_set_wins: got %0b expected 1", bus.clamp_err); end
        repeat (4) begin @(posedge clk); #1; end
        bus.clamp_clr = 1'b1;
        @(posedge clk); #1;
        bus.clamp_clr = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [35:0] q_exp[$];
        logic [35:0] e;
        logic [31:0] d_arr[6];
        logic [16:0] r_arr[6];
        logic [31:0] prev_q;
        logic [3:0]  prev_tag;
        bit          prev_stall = 1'b0;
        int          sent = 0, got = 0;
        for (int i = 0; i < 6; i++) begin
            d_arr[i] = $urandom;
            r_arr[i] = 17'($urandom_range(0, 32'h10000));
        end
        for (int c = 0; c < 30; c++) begin
            bus.out_ready = !(c >= 4 && c <= 8);
            bus.in_valid  = (sent < 6);
            if (sent < 6) begin
                bus.D        = d_arr[sent];
                bus.X        = $urandom;
                bus.One_by_N = r_arr[sent];
                bus.in_tag   = sent[3:0];
            end
            @(negedge clk);
            checks++;
            if (bus.in_ready !== ~(bus.out_valid & ~bus.out_ready)) begin
                errors++; $display("FAIL bp_in_ready: cycle %0d got %0b out_valid %0b out_ready %0b", c, bus.in_ready, bus.out_valid, bus.out_ready);
            end
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.Q !== prev_q || bus.out_tag !== prev_tag) begin
                    errors++; $display("FAIL bp_hold: cycle %0d got v=%0b q=%h tag=%h expected v=1 q=%h tag=%h", c, bus.out_valid, bus.Q, bus.out_tag, prev_q, prev_tag);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q_exp.size() == 0) begin
                    errors++; $display("FAIL bp_extra: got tag %h q %h expected no beat", bus.out_tag, bus.Q);
                end else begin
                    e = q_exp.pop_front();
                    if (bus.Q !== e[31:0] || bus.out_tag !== e[35:32]) begin
                        errors++; $display("FAIL bp_data: got tag %h q %h expected tag %h q %h", bus.out_tag, bus.Q, e[35:32], e[31:0]);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q_exp.push_back({bus.in_tag, model_q(bus.D, bus.X, bus.One_by_N)});
                sent++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_q     = bus.Q;
            prev_tag   = bus.out_tag;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (got != 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", got); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] q; logic [3:0] tg; int lat;
        bit stale = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.D        = $urandom;
            bus.One_by_N = 17'($urandom_range(0, 32'h10000));
            bus.in_tag   = 4'(i + 8);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_immediate: got %0b expected 0", bus.out_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rst_stale: got %0b expected 0", stale); end
        send_one(32'h0002_0000, 32'h0, 17'h04000, 4'h7, q, tg, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL rst_latency: got %0d expected 3", lat); end
        checks++; if (q !== 32'h0001_8000 || tg !== 4'h7) begin errors++; $display("FAIL rst_next_beat: got q %h tag %h expected q 00018000 tag 7", q, tg); end
    endtask

    task automatic test_ema();
        logic [31:0] q; logic [3:0] tg; int lat;
        send_one(32'h0064_0000, 32'h00C8_0000, 17'h04000, 4'h3, q, tg, lat);
`ifdef RECIP_EMA_EN
        checks++; if (q !== 32'h007D_0000) begin errors++; $display("FAIL ema_q: got %h expected 007d0000", q); end
`else
        checks++; if (q !== 32'h004B_0000) begin errors++; $display("FAIL x_ignored_q: got %h expected 004b0000", q); end
`endif
    endtask

    task automatic test_random();
        logic [35:0] q_exp[$];
        logic [35:0] e;
        bit          exp_clamp = 1'b0;
        for (int c = 0; c < 420; c++) begin
            bus.in_valid  = (c < 400) && ($urandom_range(0, 3) != 0);
            bus.out_ready = (c >= 400) || ($urandom_range(0, 2) != 0);
            bus.D         = $urandom;
            bus.X         = $urandom;
            bus.in_tag    = 4'($urandom);
            bus.One_by_N  = ($urandom_range(0, 7) == 0) ? 17'($urandom_range(32'h10001, 32'h1FFFF))
                                                        : 17'($urandom_range(0, 32'h10000));
            @(negedge clk);
            checks++; if (bus.clamp_err !== exp_clamp) begin errors++; $display("FAIL rnd_clamp: cycle %0d got %0b expected %0b", c, bus.clamp_err, exp_clamp); end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q_exp.size() == 0) begin
                    errors++; $display("FAIL rnd_extra: got tag %h q %h expected no beat", bus.out_tag, bus.Q);
                end else begin
                    e = q_exp.pop_front();
                    if (bus.Q !== e[31:0] || bus.out_tag !== e[35:32]) begin
                        errors++; $display("FAIL rnd_data: got tag %h q %h expected tag %h q %h", bus.out_tag, bus.Q, e[35:32], e[31:0]);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q_exp.push_back({bus.in_tag, model_q(bus.D, bus.X, bus.One_by_N)});
                if (bus.One_by_N > 17'h10000) exp_clamp = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        checks++; if (q_exp.size() != 0) begin errors++; $display("FAIL rnd_lost: got %0d beats left expected 0", q_exp.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_basic();
        test_boundaries();
        test_clamp();
        test_backpressure();
        test_reset_midstream();
        test_ema();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
